// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch stage, the combinational
// InstructionMemory and the decode/redirect logic of the pipeline.
// Signal names carry i_/o_ prefixes from the fetch unit's point of view.
//   o_imemAddr / i_imemData   : instruction memory address / returned word
//   i_redirect / i_redirectPc : flush and restart request with its target
//   o_valid / o_instr / o_pc  : FIFO head presented to decode
//   i_ready                   : decode accepts the head this cycle
//   o_misaligned              : sticky misaligned-redirect flag
// Modports: master = fetch unit side, slave = memory/pipeline side.
interface fetch_unit_if;
  logic [31:0] o_imemAddr;
  logic [31:0] i_imemData;
  logic        i_redirect;
  logic [31:0] i_redirectPc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready;
  logic        o_misaligned;

  modport master (
    output o_imemAddr, o_valid, o_instr, o_pc, o_misaligned,
    input  i_imemData, i_redirect, i_redirectPc, i_ready
  );

  modport slave (
    input  o_imemAddr, o_valid, o_instr, o_pc, o_misaligned,
    output i_imemData, i_redirect, i_redirectPc, i_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the fetch PC, drives the
// instruction memory address straight from the PC register, captures the
// returned word together with its PC into a small prefetch FIFO and offers
// the FIFO head to decode through a valid/ready handshake. A redirect
// flushes all queued fetches (a same-cycle pop still counts as consumed)
// and restarts fetch at the new target.
// Ports:
//   i_clock : clock, all state on rising edge
//   i_reset : synchronous active-high reset (overrides redirect/handshake)
//   bus     : fetch_unit_if.master (memory, redirect, decode handshake)
// Optional feature macro FETCH_ALIGN_CHECK_EN: when defined, a redirect
// with non-zero low bits sets a sticky o_misaligned flag and halts fetch
// until an aligned redirect; when undefined the low bits are cleared and
// o_misaligned is tied to 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         i_clock,
  input  logic         i_reset,
  fetch_unit_if.master bus
);

  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]  PTR_ONE = PW'(1);
  localparam logic [PW:0]    CNT_ONE = (PW+1)'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  fetch_ent_t    r_fifo [FIFO_DEPTH];
  logic [31:0]   r_fpc;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW:0]   r_count;
  logic          w_mis;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_mis;
  assign w_target = bus.i_redirectPc;
  assign w_mis    = r_mis;

  always_ff @(posedge i_clock) begin
    if (i_reset)             r_mis <= 1'b0;
    else if (bus.i_redirect) r_mis <= |bus.i_redirectPc[1:0];
  end
`else
  // Misaligned low bits are silently dropped.
  assign w_target = bus.i_redirectPc & 32'hFFFF_FFFC;
  assign w_mis    = 1'b0;
`endif

  assign w_pop  = bus.o_valid & bus.i_ready;
  // A full FIFO still accepts a fetch when the head leaves this cycle.
  assign w_push = !bus.i_redirect && !w_mis && ((r_count < DEPTH_C) || w_pop);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fpc   <= RESET_PC;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (bus.i_redirect) begin
      // Flush: any same-cycle pop is already consumed by decode.
      r_fpc   <= w_target;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fpc <= r_fpc + 32'd4;
        r_wr  <= r_wr + PTR_ONE;
      end
      if (w_pop) r_rd <= r_rd + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; o_valid qualifies it.
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_push) r_fifo[r_wr] <= '{pc: r_fpc, instr: bus.i_imemData};
  end

  assign bus.o_imemAddr   = r_fpc;
  assign bus.o_valid      = (r_count != '0);
  assign bus.o_pc         = r_fifo[r_rd].pc;
  assign bus.o_instr      = r_fifo[r_rd].instr;
  assign bus.o_misaligned = w_mis;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit
// (RESET_PC=0, FIFO_DEPTH=2). Memory model returns the address as the
// instruction word, so o_instr must always equal o_pc. Each table row gives
// the inputs applied in a cycle and the outputs expected in that same cycle
// (outputs depend only on registered state).
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_unit_if bus();

  always #5 clk = ~clk;

  // Combinational instruction memory: word == address.
  assign bus.i_imemData = bus.o_imemAddr;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        red;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        emis;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic red, input logic [31:0] rpc,
                     input logic rdy, input logic chk, input logic ev,
                     input logic [31:0] epc, input logic [31:0] eaddr,
                     input logic emis);
    vq.push_back('{rst: r, red: red, rpc: rpc, rdy: rdy, chk: chk, ev: ev,
                   epc: epc, eaddr: eaddr, emis: emis});
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  initial begin
    int lat;
    bus.i_redirect   = 1'b0;
    bus.i_redirectPc = 32'h0;
    bus.i_ready      = 1'b0;

    //  rst red rpc           rdy chk ev  epc           eaddr                   emis
    add(1, 0, 32'h0,          1,  0,  0,  32'h0,        32'h0,                  0);
    add(0, 0, 32'h0,          1,  1,  0,  32'h0,        32'h0,                  0);
    add(0, 0, 32'h0,          1,  1,  1,  32'h0,        32'h4,                  0);
    add(0, 0, 32'h0,          1,  1,  1,  32'h4,        32'h8,                  0);
    add(0, 0, 32'h0,          1,  1,  1,  32'h8,        32'hC,                  0);
    add(0, 0, 32'h0,          1,  1,  1,  32'hC,        32'h10,                 0);
    add(0, 0, 32'h0,          0,  1,  1,  32'h10,       32'h14,                 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,        0,  1,  1,  32'h10,       32'h18,                 0);
    add(0, 0, 32'h0,          1,  1,  1,  32'h10,       32'h18,                 0);
    add(0, 0, 32'h0,          1,  1,  1,  32'h14,       32'h1C,                 0);
    add(0, 1, 32'h100,        1,  1,  1,  32'h18,       32'h20,                 0);
    add(0, 0, 32'h0,          1,  1,  0,  32'h0,        32'h100,                0);
    add(0, 1, 32'hFFFF_FFF8,  1,  1,  1,  32'h100,      32'h104,                0);
    add(0, 0, 32'h0,          1,  1,  0,  32'h0,        32'hFFFF_FFF8,          0);
    add(0, 0, 32'h0,          1,  1,  1,  32'hFFFF_FFF8, 32'hFFFF_FFFC,         0);
    add(0, 0, 32'h0,          1,  1,  1,  32'hFFFF_FFFC, 32'h0,                 0);
    add(0, 1, 32'h103,        1,  1,  1,  32'h0,        32'h4,                  0);
    add(0, 0, 32'h0,          1,  1,  0,  32'h0,        ALN ? 32'h103 : 32'h100, ALN);
    add(0, 1, 32'h200,        1,  1,  !ALN, 32'h100,    ALN ? 32'h103 : 32'h104, ALN);
    add(0, 0, 32'h0,          1,  1,  0,  32'h0,        32'h200,                0);
    add(0, 1, 32'h301,        1,  1,  1,  32'h200,      32'h204,                0);
    add(1, 1, 32'h400,        0,  1,  0,  32'h0,        ALN ? 32'h301 : 32'h300, ALN);
    add(0, 0, 32'h0,          0,  1,  0,  32'h0,        32'h0,                  0);
    add(0, 0, 32'h0,          0,  1,  1,  32'h0,        32'h4,                  0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,        0,  1,  1,  32'h0,        32'h8,                  0);
    add(0, 0, 32'h0,          1,  1,  1,  32'h0,        32'h8,                  0);
    add(0, 0, 32'h0,          1,  1,  1,  32'h4,        32'hC,                  0);
    add(0, 0, 32'h0,          1,  1,  1,  32'h8,        32'h10,                 0);
    add(0, 0, 32'h0,          1,  1,  1,  32'hC,        32'h14,                 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst              = vq[i].rst;
      bus.i_redirect   = vq[i].red;
      bus.i_redirectPc = vq[i].rpc;
      bus.i_ready      = vq[i].rdy;
      #1;
      if (vq[i].chk) begin
        chk("valid",     i, {31'h0, bus.o_valid},      {31'h0, vq[i].ev});
        chk("imemAddr",  i, bus.o_imemAddr,            vq[i].eaddr);
        chk("misaligned", i, {31'h0, bus.o_misaligned}, {31'h0, vq[i].emis});
        if (vq[i].ev && bus.o_valid) begin
          chk("pc",    i, bus.o_pc,    vq[i].epc);
          chk("instr", i, bus.o_instr, vq[i].epc);
        end
      end
    end

    // First-fetch latency after reset release, bounded by a cycle budget.
    @(negedge clk);
    rst            = 1'b1;
    bus.i_redirect = 1'b0;
    bus.i_ready    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("valid_after_reset", -1, {31'h0, bus.o_valid}, 32'h0);
    lat = 0;
    while (!bus.o_valid && lat < 8) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("first_valid_latency", -1, lat, 1);
    chk("first_pc", -1, bus.o_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage between the CPU pipeline and the combinational InstructionMemory.
- Owns the fetch PC, drives the memory address, and captures the returned word with its PC into a small prefetch FIFO.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes in-flight fetches and restarts at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0
FIFO_DEPTH, 2, prefetch entries; power of two, 2..8

Ports:
i_clock  input  1  clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
o_imemAddr  output  32  fetch address to InstructionMemory; equals fetch PC register
i_imemData  input  32  instruction word at o_imemAddr, combinational same cycle
i_redirect  input  1  flush and restart fetch at i_redirectPc
i_redirectPc  input  32  redirect target
o_valid  output  1  FIFO head holds a valid instruction
o_instr  output  32  instruction at FIFO head
o_pc  output  32  PC of instruction at FIFO head
i_ready  input  1  decode accepts head this cycle
o_misaligned  output  1  misaligned-redirect flag; see Optional Feature

Behaviour:
- State:
  - fpc[31:0]: fetch PC.
  - FIFO of FIFO_DEPTH entries of {pc, instr}.
  - rd/wr pointers of log2(FIFO_DEPTH) bits.
  - count of log2(FIFO_DEPTH)+1 bits.
- Reset (i_reset=1 at edge):
  - fpc<=RESET_PC; count, pointers <=0.
  - o_valid=0, o_misaligned=0.
  - o_imemAddr=RESET_PC the cycle after reset.
  - o_instr/o_pc are don't-care while o_valid=0.
  - Reset overrides redirect and handshake in the same cycle.
- o_imemAddr = fpc, driven directly from the register (no combinational path from inputs).
- pop = o_valid & i_ready.
- push = !i_redirect & (count<FIFO_DEPTH | pop).
  - Full with a simultaneous pop still pushes (full-throughput).
- On push:
  - Write {fpc, i_imemData} at wr pointer.
  - fpc<=fpc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- On pop: advance rd pointer.
- count <= count + push - pop.
- o_valid = (count!=0); head is driven from the rd pointer entry.
- Latency: an instruction fetched in cycle N is visible at the head in cycle N+1 when the FIFO was empty.
- Steady state with i_ready=1: one instruction per cycle, PCs consecutive by 4.
- Stall (i_ready=0):
  - The FIFO fills to FIFO_DEPTH, then push stops and fpc holds.
  - o_instr and o_pc are held stable while o_valid=1 and no pop occurs.
- Redirect (i_redirect=1):
  - Pop in the same cycle counts as consumed by decode (handshake honoured); all other entries are discarded.
  - Next state: count<=0, pointers<=0, fpc<=target (below). No push this cycle.
  - Next cycle: o_valid=0, o_imemAddr=target.
  - First redirected instruction is valid 2 cycles after the redirect cycle.
- Target without the macro: {i_redirectPc[31:2], 2'b00}, so misaligned low bits are silently cleared.
- Back-to-back redirects: the last one wins and each one flushes.
- Pointers wrap naturally at FIFO_DEPTH.

Optional Feature:
Macro: FETCH_ALIGN_CHECK_EN
- Defined:
  - A redirect with i_redirectPc[1:0]!=0 sets sticky o_misaligned<=1 and loads fpc<=i_redirectPc unmodified.
  - While o_misaligned=1, push is suppressed, FIFO stays empty and o_valid=0.
  - An aligned redirect clears o_misaligned and resumes fetch.
  - Reset clears o_misaligned.
- Undefined:
  - o_misaligned is tied 0.
  - Low bits are cleared as described in Behaviour.

Test Plan:
- Reset then release, i_ready=1, memory word = address -> o_valid first high 1 cycle after release; o_pc sequence 0,4,8,12; o_instr==o_pc every cycle.
- i_ready=0 for 6 cycles after the first valid (FIFO_DEPTH=2) -> count saturates at 2; o_imemAddr holds 8; head stays pc=0. Then i_ready=1 -> pcs 0,4,8,... delivered with no gap and no duplicate.
- i_redirect=1, i_redirectPc=32'h100 while 2 entries are queued and i_ready=1 -> head entry consumed; next cycle o_valid=0 and o_imemAddr=32'h100; the cycle after, o_pc=32'h100.
- Redirect to 32'hFFFF_FFF8 -> o_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Redirect to 32'h103:
  - Macro undefined: fetch resumes at 32'h100.
  - Macro defined: o_misaligned=1 and o_valid stays 0; a later redirect to 32'h200 clears the flag and delivers pc 32'h200.
- i_reset asserted mid-stream with i_redirect=1 in the same cycle -> next cycle o_valid=0, o_imemAddr=RESET_PC, o_misaligned=0.
